// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, requests imem and buffers one instruction for decode.
// Fetch latency = memory latency + 1 cycle; the memory is not re-requested while decode stalls the buffer.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic        r_kill;
  logic        r_vld;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;

  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_inc;

  assign w_redir_pc = redirect_pc & ~32'h3;
  assign w_pc_inc   = r_pc + 32'(PC_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_tgt    <= RESET_PC;
      r_kill   <= 1'b0;
      r_vld    <= 1'b0;
      r_instr  <= 32'h0;
      r_if_pc  <= 32'h0;
      r_if_pc4 <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (!imem_ack) begin
            // Address must stay put until the ack; remember where to go instead.
            if (redirect_valid) begin
              r_kill <= 1'b1;
              r_tgt  <= w_redir_pc;
            end
          end else if (r_kill || redirect_valid) begin
            r_kill <= 1'b0;
            r_pc   <= redirect_valid ? w_redir_pc : r_tgt;
          end else begin
            r_instr  <= imem_rdata;
            r_if_pc  <= r_pc;
            r_if_pc4 <= w_pc_inc;
            r_vld    <= 1'b1;
            r_pc     <= w_pc_inc;
            r_state  <= S_FULL;
          end
        end
        S_FULL: begin
          if (redirect_valid) begin
            r_vld   <= 1'b0;
            r_pc    <= w_redir_pc;
            r_state <= S_REQ;
          end else if (if_ready) begin
            r_vld   <= 1'b0;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign if_valid    = r_vld;
  assign if_instr    = r_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, stall, redirects, wrap and reset.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_chk = 0;
  int n_bad = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr, input logic vld);
    check({tag, ".req"},  32'(imem_req), 32'(req));
    check({tag, ".addr"}, imem_addr, addr);
    check({tag, ".vld"},  32'(if_valid), 32'(vld));
  endtask

  task automatic chk_buf(input string tag, input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    check({tag, ".instr"}, if_instr, instr);
    check({tag, ".pc"},    if_pc, pc);
    check({tag, ".pc4"},   if_pc_plus4, pc4);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
    tick(); tick();
    chk_fetch("rst", 1'b0, 32'h0, 1'b0);
    chk_buf("rst", 32'h0, 32'h0, 32'h0);

    // Release: one IDLE cycle, then the first request.
    reset = 1'b0;
    tick();
    chk_fetch("first_req", 1'b1, 32'h0, 1'b0);

    // Sequential fetch with an immediate ack: addresses 0,4,8,C, one instruction per 2 cycles.
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i);
      chk_fetch("seq_req", 1'b1, 32'(4 * i), 1'b0);
      tick();
      imem_ack = 1'b0;
      chk_fetch("seq_full", 1'b0, 32'(4 * i + 4), 1'b1);
      chk_buf("seq_full", 32'hA000_0000 + 32'(i), 32'(4 * i), 32'(4 * i + 4));
      tick();
    end

    // Decode stall: buffer holds, no request, stray ack ignored.
    imem_ack = 1'b1; imem_rdata = 32'h1111_0010; if_ready = 1'b0;
    tick();
    imem_rdata = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      chk_fetch("stall", 1'b0, 32'h14, 1'b1);
      chk_buf("stall", 32'h1111_0010, 32'h10, 32'h14);
      tick();
    end
    imem_ack = 1'b0; if_ready = 1'b1;
    check("stall_still_vld", 32'(if_valid), 32'h1);
    tick();
    chk_fetch("stall_done", 1'b1, 32'h14, 1'b0);

    // Redirect while waiting for a late ack: returned word is dropped.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk_fetch("kill_hold1", 1'b1, 32'h14, 1'b0);
    tick();
    chk_fetch("kill_hold2", 1'b1, 32'h14, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk_fetch("kill_drop", 1'b1, 32'h100, 1'b0);
    check("kill_buf_pc", if_pc, 32'h10);
    imem_rdata = 32'h0000_0100;
    tick();
    imem_ack = 1'b0;
    chk_fetch("kill_refetch", 1'b0, 32'h104, 1'b1);
    chk_buf("kill_refetch", 32'h0000_0100, 32'h100, 32'h104);
    tick();

    // Two redirects during one wait: the later one wins.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    tick();
    chk_fetch("redir2", 1'b1, 32'h200, 1'b0);
    imem_rdata = 32'h0000_0200;
    tick();
    imem_ack = 1'b0;
    chk_buf("redir2_buf", 32'h0000_0200, 32'h200, 32'h204);
    tick();

    // Redirect in FULL with if_ready=1: buffer flushed, fetch resumes at target.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0204;
    tick();
    imem_ack = 1'b0;
    check("full_pre_vld", 32'(if_valid), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk_fetch("full_flush", 1'b1, 32'h40, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0040;
    tick();
    imem_ack = 1'b0;
    chk_buf("full_redir_buf", 32'h0000_0040, 32'h40, 32'h44);
    tick();

    // Misaligned redirect near the top of memory: aligned down, then PC wraps to 0.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b1;
    tick();
    chk_fetch("wrap_addr", 1'b1, 32'hFFFF_FFFC, 1'b0);
    imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0;
    chk_fetch("wrap_full", 1'b0, 32'h0, 1'b1);
    chk_buf("wrap_buf", 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0);
    tick();
    chk_fetch("wrap_next", 1'b1, 32'h0, 1'b0);

    // Reset in REQ with a pending kill: kill must not survive.
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0; reset = 1'b1;
    tick();
    chk_fetch("rst_req", 1'b0, 32'h0, 1'b0);
    chk_buf("rst_req", 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
    chk_fetch("rst_req_first", 1'b1, 32'h0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h5555_0000;
    tick();
    imem_ack = 1'b0; if_ready = 1'b0;
    chk_buf("rst_nokill", 32'h5555_0000, 32'h0, 32'h4);

    // Reset in FULL, and a redirect during IDLE is ignored.
    reset = 1'b1;
    tick();
    chk_fetch("rst_full", 1'b0, 32'h0, 1'b0);
    chk_buf("rst_full", 32'h0, 32'h0, 32'h0);
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk_fetch("idle_redir", 1'b1, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
